// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: rotates a low row drive, debounces every key on its
// row's sample, and queues press/release events in a 4-deep FIFO.
module keypad_scanner #(
  parameter int SCAN_DIV    = 12000,
  parameter int DEB_SAMPLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  col,
  output logic [3:0]  row,
  output logic [15:0] key_state,
  output logic        evt_valid,
  input  logic        evt_ready,
  output logic        evt_press,
  output logic [3:0]  evt_code,
  output logic        overflow
);

  localparam int              DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [3:0]      DEB_LIM  = 4'(DEB_SAMPLES);

  typedef enum logic [2:0] {
    SER_IDLE,
    SER_C0,
    SER_C1,
    SER_C2,
    SER_C3
  } ser_state_t;

  logic [DIV_W-1:0] r_div;
  logic [1:0]       r_row_idx;
  logic [3:0]       r_row;
  logic [3:0]       r_sample;
  logic [1:0]       r_samp_row;
  ser_state_t       r_ser_state;
  logic [15:0]      r_key_state;
  logic [3:0]       r_cnt [16];
  logic [4:0]       r_mem [4];
  logic [1:0]       r_wr_ptr;
  logic [1:0]       r_rd_ptr;
  logic [2:0]       r_count;
  logic             r_overflow;

  logic       w_tick;
  logic       w_ser_active;
  logic [1:0] w_ser_col;
  logic [3:0] w_key;
  logic       w_raw;
  logic       w_cur;
  logic [3:0] w_cnt_cur;
  logic [3:0] w_cnt_inc;
  logic       w_differs;
  logic       w_accept;
  logic       w_push_ok;
  logic       w_pop;
  logic       w_full;

  assign w_tick = (r_div == DIV_LAST);

  // Row driver and sampler: the sample is taken on the tick, before the row moves on.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div      <= '0;
      r_row_idx  <= 2'd0;
      r_row      <= 4'b1110;
      r_sample   <= 4'h0;
      r_samp_row <= 2'd0;
    end else if (w_tick) begin
      r_div      <= '0;
      r_sample   <= ~col;
      r_samp_row <= r_row_idx;
      r_row_idx  <= r_row_idx + 2'd1;
      r_row      <= {r_row[2:0], r_row[3]};
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ser_state <= SER_IDLE;
    end else if (w_tick) begin
      r_ser_state <= SER_C0;
    end else begin
      case (r_ser_state)
        SER_C0:  r_ser_state <= SER_C1;
        SER_C1:  r_ser_state <= SER_C2;
        SER_C2:  r_ser_state <= SER_C3;
        default: r_ser_state <= SER_IDLE;
      endcase
    end
  end

  always_comb begin
    w_ser_active = 1'b1;
    w_ser_col    = 2'd0;
    case (r_ser_state)
      SER_C0:  w_ser_col = 2'd0;
      SER_C1:  w_ser_col = 2'd1;
      SER_C2:  w_ser_col = 2'd2;
      SER_C3:  w_ser_col = 2'd3;
      default: w_ser_active = 1'b0;
    endcase
  end

  assign w_key     = {r_samp_row, w_ser_col};
  assign w_raw     = r_sample[w_ser_col];
  assign w_cur     = r_key_state[w_key];
  assign w_cnt_cur = r_cnt[w_key];
  assign w_cnt_inc = w_cnt_cur + 4'd1;
  assign w_differs = (w_raw != w_cur);
  assign w_accept  = w_ser_active && w_differs && (w_cnt_inc == DEB_LIM);

  // One key per serializer cycle: count disagreeing samples, clear on any agreeing one.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_key_state <= 16'h0000;
      for (int i = 0; i < 16; i++) r_cnt[i] <= 4'h0;
    end else if (w_ser_active) begin
      if (!w_differs) begin
        r_cnt[w_key] <= 4'h0;
      end else if (w_accept) begin
        r_cnt[w_key]       <= 4'h0;
        r_key_state[w_key] <= w_raw;
      end else begin
        r_cnt[w_key] <= w_cnt_inc;
      end
    end
  end

  // Handshake: an event transfers on every cycle where evt_valid and evt_ready are both 1;
  // the head is held unchanged while evt_valid=1 and evt_ready=0.
  assign w_full    = (r_count == 3'd4);
  assign w_pop     = evt_valid && evt_ready;
  assign w_push_ok = w_accept && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) r_mem[i] <= 5'h00;
      r_wr_ptr   <= 2'd0;
      r_rd_ptr   <= 2'd0;
      r_count    <= 3'd0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= {w_raw, w_key};
        r_wr_ptr        <= r_wr_ptr + 2'd1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 2'd1;
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
      if (w_accept && !w_push_ok) r_overflow <= 1'b1;
    end
  end

  assign row       = r_row;
  assign key_state = r_key_state;
  assign evt_valid = (r_count != 3'd0);
  assign evt_press = r_mem[r_rd_ptr][4];
  assign evt_code  = r_mem[r_rd_ptr][3:0];
  assign overflow  = r_overflow;

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 12000, the number of clk cycles each row stays driven (1 ms at 12 MHz).
REQ-002 The block SHALL have parameter DEB_SAMPLES, default 3, the number of consecutive agreeing samples needed to accept a key change (range 1..15).
REQ-003 The block SHALL have port clk, input, 1 bit: system clock, 12 MHz; the only clock.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port col, input, 4 bits: keypad columns, active-low (a pressed key pulls its column to 0).
REQ-006 The block SHALL have port row, output, 4 bits: keypad rows, one-hot-low drive.
REQ-007 The block SHALL have port key_state, output, 16 bits: debounced level per key, bit index = key_code, 1 = pressed.
REQ-008 The block SHALL have port evt_valid, output, 1 bit: asserted while the event FIFO is non-empty.
REQ-009 The block SHALL have port evt_ready, input, 1 bit: consumer accepts the head event.
REQ-010 The block SHALL have port evt_press, output, 1 bit: head event type, 1 = press, 0 = release.
REQ-011 The block SHALL have port evt_code, output, 4 bits: head event key code = {row_index[1:0], col_index[1:0]}.
REQ-012 The block SHALL have port overflow, output, 1 bit: sticky flag set when an event is dropped.

Function
REQ-013 The block SHALL use a divider counting 0..SCAN_DIV-1 that wraps to 0, producing a one-cycle tick when it reaches SCAN_DIV-1.
REQ-014 The row index r SHALL advance 0→1→2→3→0 on each tick, with row = 1110, 1101, 1011, 0111 for r = 0..3.
REQ-015 On the tick cycle, the block SHALL capture ~col as the raw sample for row r before r advances, so each row is driven for a full SCAN_DIV cycles before sampling.
REQ-016 Each key SHALL have a counter of 4 bits or more, compared only when its row is sampled.
  - raw ≠ key_state bit: the counter increments.
  - raw = key_state bit: the counter clears.
  - When the counter reaches DEB_SAMPLES: the key_state bit toggles, the counter clears, and an event is generated.
REQ-017 In the 4 cycles after a tick, a serializer SHALL process columns 0,1,2,3 of the sampled row, one per cycle (column c at tick+1+c).
  - The key_state update and the FIFO push for column c SHALL both occur in cycle tick+1+c.
  - Multiple changes in one row SHALL therefore enqueue in ascending column order.
REQ-018 The event FIFO SHALL hold 4 entries of {press, code}, ordered first-in first-out.
  - The head SHALL drive evt_press and evt_code.
  - evt_valid SHALL rise the cycle after a push into an empty FIFO.
REQ-019 A pop SHALL occur on any cycle with evt_valid=1 and evt_ready=1, and the next entry (if any) SHALL appear the following cycle.
REQ-020 evt_press and evt_code SHALL hold stable while evt_valid=1 and evt_ready=0.
REQ-021 A push and a pop in the same cycle SHALL both succeed, including when the FIFO is full; the occupancy count stays unchanged.
REQ-022 A push when the FIFO is full with no simultaneous pop SHALL drop the new event.
  - overflow SHALL be set to 1 and held until reset.
  - key_state SHALL still update.
REQ-023 Latency: a key pressed stably before a row-r tick SHALL be accepted on its DEB_SAMPLES-th sample and appear at the FIFO head at tick+2+c when the FIFO is empty.
  - The worst case from press to evt_valid is DEB_SAMPLES×4×SCAN_DIV+SCAN_DIV+5 cycles.
REQ-024 A sample bounce (raw = key_state) before DEB_SAMPLES is reached SHALL clear that key's counter, and no event SHALL be generated.
REQ-025 Simultaneous presses in different rows SHALL produce events in scan order.

Reset
REQ-026 While rst=1 on a rising clk edge, all state SHALL take its reset value on that edge.
  - row=1110, r=0, divider=0.
  - key_state=0, all debounce counters=0, serializer idle.
  - FIFO empty, evt_valid=0, evt_press=0, evt_code=0, overflow=0.
REQ-027 Reset asserted mid-scan or mid-serialization SHALL discard all pending and queued events; the scan SHALL restart at row 0 on the first cycle after rst deasserts.

Verification
REQ-028 With SCAN_DIV=8 and DEB_SAMPLES=3, hold key 6 (row 1, col 2) pressed from reset release.
  - Required: one event {press=1, code=6}; key_state=0x0040; nothing further while held.
REQ-029 Release key 6 afterwards.
  - Required: one event {press=0, code=6} after 3 row-1 samples of release; key_state=0x0000.
REQ-030 Toggle key 6 every 2 scans (pattern 1,0,1,0 across row-1 samples).
  - Required: no event and key_state unchanged.
REQ-031 Press keys 8, 9 and 11 (row 2) simultaneously with evt_ready=1.
  - Required: events with codes 8, 9, 11 in that order on consecutive valid cycles.
REQ-032 Hold evt_ready=0 and generate 5 press events.
  - Required: FIFO holds the first 4 and overflow=1.
  - Then raise evt_ready: exactly 4 events drain in order, and overflow stays 1.
REQ-033 Assert rst for 1 cycle while 2 events are queued.
  - Required: next cycle evt_valid=0, key_state=0, row=1110, overflow=0.
